// File: rtl/latch_bank_write_arbiter.sv
// latch_bank_write_arbiter: arbitrates N_REQ requesters onto one bank of gate-level
// D-latches and plays each grant out as a setup / enable / hold latch write.
// Build option: define LATCH_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
// Latency: gnt one cycle after req is seen in IDLE; done S+E+H-1 cycles after gnt.
// Backpressure: req is held until gnt; requests are only sampled in IDLE.

module latch_bank_write_arbiter #(
  parameter int N_REQ        = 4,
  parameter int DW           = 8,
  parameter int AW           = 2,
  parameter int SETUP_CYCLES = 1,
  parameter int EN_CYCLES    = 2,
  parameter int HOLD_CYCLES  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*AW-1:0] addr,
  input  logic [N_REQ*DW-1:0] wdata,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    done,
  output logic                busy,
  output logic [DW-1:0]       latch_d,
  output logic [(2**AW)-1:0]  latch_en
);

  localparam int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int EW    = 2 ** AW;
  localparam int MAXC0 = (SETUP_CYCLES > EN_CYCLES) ? SETUP_CYCLES : EN_CYCLES;
  localparam int MAXC  = (MAXC0 > HOLD_CYCLES) ? MAXC0 : HOLD_CYCLES;
  localparam int CW    = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ENABLE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [AW-1:0]    cap_addr;
  logic [N_REQ-1:0] cap_win;
  logic             win_vld;
  logic [PW-1:0]    win_idx;

`ifdef LATCH_ARB_FIXED_PRIO_EN
  // Fixed priority: the lowest-indexed active request wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_vld = 1'b1;
        win_idx = PW'(i);
      end
    end
  end
`else
  logic [PW-1:0] rr_ptr;

  // Round-robin: first active request at or after rr_ptr, wrapping; scanning
  // from the far end leaves the nearest candidate as the final assignment.
  always_comb begin
    int idx;
    idx     = 0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr) + i) % N_REQ;
      if (req[idx]) begin
        win_vld = 1'b1;
        win_idx = PW'(idx);
      end
    end
  end

  // Pointer moves just past each granted index.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (state == IDLE && win_vld) begin
      rr_ptr <= (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + PW'(1);
    end
  end
`endif

  // Write sequencer; every output is produced from registered state so the
  // latch clock changes only on clk edges and never glitches between words.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      cap_addr <= '0;
      cap_win  <= '0;
      gnt      <= '0;
      done     <= '0;
      busy     <= 1'b0;
      latch_d  <= '0;
      latch_en <= '0;
    end else begin
      gnt  <= '0;
      done <= '0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            state    <= SETUP;
            cnt      <= CW'(SETUP_CYCLES - 1);
            cap_addr <= addr[win_idx*AW +: AW];
            cap_win  <= N_REQ'(1) << win_idx;
            gnt      <= N_REQ'(1) << win_idx;
            latch_d  <= wdata[win_idx*DW +: DW];
            busy     <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            state    <= ENABLE;
            cnt      <= CW'(EN_CYCLES - 1);
            latch_en <= EW'(1) << cap_addr;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ENABLE: begin
          if (cnt == '0) begin
            state    <= HOLD;
            cnt      <= CW'(HOLD_CYCLES - 1);
            latch_en <= '0;
            // A one-cycle hold phase is also its last cycle.
            if (HOLD_CYCLES == 1) done <= cap_win;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) done <= cap_win;
          end
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          latch_en <= '0;
        end
      endcase
    end
  end

endmodule
